// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: voter configuration encodings and redundancy FSM states for the replicated EX ALUs.
package cv32e40p_pkg;
  localparam logic [2:0] SEL_TMR_NOM = 3'b000;
  localparam logic [2:0] SEL_SPARE_0 = 3'b001;
  localparam logic [2:0] SEL_SPARE_1 = 3'b010;
  localparam logic [2:0] SEL_SPARE_2 = 3'b011;
  localparam logic [2:0] SEL_DMR     = 3'b100;
  localparam logic [2:0] SEL_SIMPLEX = 3'b101;
  localparam logic [2:0] SEL_FAILED  = 3'b111;
  typedef enum logic [2:0] {
    FT_TMR_NOM,
    FT_TMR_SPARE,
    FT_DMR,
    FT_SIMPLEX,
    FT_FAILED
  } alu_ft_state_e;
  // k is the faulty primary ALU that the spare replaces; only used in FT_TMR_SPARE
  function automatic logic [2:0] ft_state_sel(alu_ft_state_e s, logic [1:0] k);
    return s == FT_TMR_NOM   ? SEL_TMR_NOM :
           s == FT_TMR_SPARE ? (k == 2'd0 ? SEL_SPARE_0 : k == 2'd1 ? SEL_SPARE_1 : SEL_SPARE_2) :
           s == FT_DMR       ? SEL_DMR :
           s == FT_SIMPLEX   ? SEL_SIMPLEX : SEL_FAILED;
  endfunction
endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// cv32e40p_ft_err_counter: per-ALU saturating mismatch counter with threshold detect, freeze, leak decrement and clear.
module cv32e40p_ft_err_counter #(
  parameter int ERR_THRESHOLD = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic frozen,
  output logic hit
);
  logic [CNT_W-1:0] cnt;
  assign hit = inc & ~clr & ~frozen & (cnt == CNT_W'(ERR_THRESHOLD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (!frozen && inc) cnt <= cnt + 1'b1;
    else if (!frozen && dec && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/cv32e40p_alu_redundancy_ctrl.sv
// cv32e40p_alu_redundancy_ctrl: tracks ALU voter mismatches and reconfigures voter/clock enables at instruction boundaries.
module cv32e40p_alu_redundancy_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int ERR_THRESHOLD = 4,
  parameter int CNT_W         = 3,
  parameter int LEAK_PERIOD   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid_i,
  input  logic [3:0] err_alu_i,
  input  logic       ex_ready_i,
  input  logic       clear_cnt_i,
  output logic [2:0] sel_mux_ex_o,
  output logic [3:0] clock_enable_alu_o,
  output logic [3:0] perm_fault_o,
  output logic       degraded_o,
  output logic       fatal_o
);
  localparam int LW = LEAK_PERIOD > 1 ? $clog2(LEAK_PERIOD) : 1;
  alu_ft_state_e state_q, state_d;
  logic [3:0]    eff, hit, en_d;
  logic [2:0]    sel_d, healthy;
  logic [1:0]    k;
  logic [LW-1:0] leak_q;
  logic          leak_fire;
  assign eff       = alu_valid_i ? err_alu_i & clock_enable_alu_o : 4'b0000;
  assign leak_fire = (LEAK_PERIOD != 0) && alu_valid_i && eff == 4'b0000 && leak_q == LW'(LEAK_PERIOD - 1);
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    cv32e40p_ft_err_counter #(.ERR_THRESHOLD(ERR_THRESHOLD), .CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (eff[i]),
      .dec    (leak_fire),
      .clr    (clear_cnt_i),
      .frozen (perm_fault_o[i]),
      .hit    (hit[i])
    );
  end
  // a faulty spare leaves the primary triple intact, so nominal TMR is kept
  always_comb begin
    healthy = 3'($countones(~perm_fault_o));
    k       = perm_fault_o[0] ? 2'd0 : perm_fault_o[1] ? 2'd1 : 2'd2;
    state_d = healthy == 3'd4 ? FT_TMR_NOM :
              healthy == 3'd3 ? (perm_fault_o[3] ? FT_TMR_NOM : FT_TMR_SPARE) :
              healthy == 3'd2 ? FT_DMR :
              healthy == 3'd1 ? FT_SIMPLEX : FT_FAILED;
    sel_d   = ft_state_sel(state_d, k);
    en_d    = state_d == FT_TMR_NOM ? 4'b0111 : ~perm_fault_o;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q            <= FT_TMR_NOM;
      sel_mux_ex_o       <= SEL_TMR_NOM;
      clock_enable_alu_o <= 4'b0111;
      perm_fault_o       <= 4'b0000;
      leak_q             <= '0;
    end else begin
      perm_fault_o <= perm_fault_o | hit;
      if (clear_cnt_i || eff != 4'b0000 || leak_fire) leak_q <= '0;
      else if (alu_valid_i) leak_q <= leak_q + 1'b1;
      if (ex_ready_i) begin
        state_q            <= state_d;
        sel_mux_ex_o       <= sel_d;
        clock_enable_alu_o <= en_d;
      end
    end
  assign degraded_o = state_q == FT_DMR || state_q == FT_SIMPLEX;
  assign fatal_o    = state_q == FT_FAILED;
endmodule

// File: tb/tb_cv32e40p_alu_redundancy_ctrl.sv
// tb_cv32e40p_alu_redundancy_ctrl: scoreboard bench for the ALU redundancy controller (LEAK_PERIOD = 4).
module tb_cv32e40p_alu_redundancy_ctrl;
  localparam int TH = 4;
  localparam int LP = 4;
  typedef struct {
    logic [2:0] sel;
    logic [3:0] en;
    logic [3:0] pf;
    logic       deg;
    logic       fat;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid_i = 1'b0;
  logic [3:0] err_alu_i = 4'b0000;
  logic       ex_ready_i = 1'b0;
  logic       clear_cnt_i = 1'b0;
  logic [2:0] sel_mux_ex_o;
  logic [3:0] clock_enable_alu_o, perm_fault_o;
  logic       degraded_o, fatal_o;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];
  int m_cnt[4];
  int m_leak;
  logic [3:0] m_pf, m_en;
  logic [2:0] m_sel;
  logic m_deg, m_fat;

  cv32e40p_alu_redundancy_ctrl #(.ERR_THRESHOLD(TH), .CNT_W(3), .LEAK_PERIOD(LP)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_valid_i        (alu_valid_i),
    .err_alu_i          (err_alu_i),
    .ex_ready_i         (ex_ready_i),
    .clear_cnt_i        (clear_cnt_i),
    .sel_mux_ex_o       (sel_mux_ex_o),
    .clock_enable_alu_o (clock_enable_alu_o),
    .perm_fault_o       (perm_fault_o),
    .degraded_o         (degraded_o),
    .fatal_o            (fatal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_leak = 0;
    m_pf   = 4'b0000;
    m_en   = 4'b0111;
    m_sel  = 3'b000;
    m_deg  = 1'b0;
    m_fat  = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    vectors++;
    if ({sel_mux_ex_o, clock_enable_alu_o, perm_fault_o, degraded_o, fatal_o} !== {3'b000, 4'b0111, 4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s: got sel=%b en=%b pf=%b deg=%b fat=%b, want sel=000 en=0111 pf=0000 deg=0 fat=0",
               name, sel_mux_ex_o, clock_enable_alu_o, perm_fault_o, degraded_o, fatal_o);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    alu_valid_i = 1'b0; err_alu_i = 4'b0000; ex_ready_i = 1'b0; clear_cnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // drive one cycle, predict from the specification, then compare the popped expectation
  task automatic cycle(input logic v, input logic [3:0] e, input logic r, input logic c);
    logic [3:0] eff, npf;
    logic fire;
    int h, k;
    exp_t x, got;
    alu_valid_i = v; err_alu_i = e; ex_ready_i = r; clear_cnt_i = c;
    eff  = v ? (e & m_en) : 4'b0000;
    fire = v && eff == 4'b0000 && m_leak == LP - 1;
    npf  = m_pf;
    for (int i = 0; i < 4; i++) begin
      if (c) m_cnt[i] = 0;
      else if (!m_pf[i]) begin
        if (eff[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == TH) npf[i] = 1'b1;
        end else if (fire && m_cnt[i] > 0) m_cnt[i]--;
      end
    end
    m_leak = (c || eff != 4'b0000 || fire) ? 0 : v ? m_leak + 1 : m_leak;
    if (r) begin
      h = 4 - $countones(m_pf);
      k = m_pf[0] ? 0 : m_pf[1] ? 1 : 2;
      m_deg = 1'b0; m_fat = 1'b0;
      if (h == 4 || (h == 3 && m_pf[3])) begin m_sel = 3'b000; m_en = 4'b0111; end
      else if (h == 3) begin m_sel = 3'(k + 1); m_en = ~m_pf; end
      else if (h == 2) begin m_sel = 3'b100; m_en = ~m_pf; m_deg = 1'b1; end
      else if (h == 1) begin m_sel = 3'b101; m_en = ~m_pf; m_deg = 1'b1; end
      else begin m_sel = 3'b111; m_en = 4'b0000; m_fat = 1'b1; end
    end
    m_pf = npf;
    x = '{sel: m_sel, en: m_en, pf: m_pf, deg: m_deg, fat: m_fat};
    sb.push_back(x);
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    got = '{sel: sel_mux_ex_o, en: clock_enable_alu_o, pf: perm_fault_o, deg: degraded_o, fat: fatal_o};
    vectors++;
    if ({got.sel, got.en, got.pf, got.deg, got.fat} !== {x.sel, x.en, x.pf, x.deg, x.fat}) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got sel=%b en=%b pf=%b deg=%b fat=%b, want sel=%b en=%b pf=%b deg=%b fat=%b",
               $time, got.sel, got.en, got.pf, got.deg, got.fat, x.sel, x.en, x.pf, x.deg, x.fat);
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] sel, input logic [3:0] en, input logic [3:0] pf,
                            input logic deg, input logic fat);
    vectors++;
    if ({sel_mux_ex_o, clock_enable_alu_o, perm_fault_o, degraded_o, fatal_o} !== {sel, en, pf, deg, fat}) begin
      miscompares++;
      $display("FAIL %s: got sel=%b en=%b pf=%b deg=%b fat=%b, want sel=%b en=%b pf=%b deg=%b fat=%b",
               name, sel_mux_ex_o, clock_enable_alu_o, perm_fault_o, degraded_o, fatal_o, sel, en, pf, deg, fat);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_vals("reset_release");
  endtask

  task automatic test_spare_swap();
    apply_reset();
    repeat (3) cycle(1, 4'b0010, 1, 0);
    expect_out("swap_pre", 3'b000, 4'b0111, 4'b0000, 0, 0);
    cycle(1, 4'b0010, 1, 0);
    expect_out("swap_fault", 3'b000, 4'b0111, 4'b0010, 0, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("swap_reconf", 3'b010, 4'b1101, 4'b0010, 0, 0);
  endtask

  task automatic test_boundary_hold();
    apply_reset();
    repeat (4) cycle(1, 4'b0001, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 4'b0000, 0, 0);
    expect_out("hold", 3'b000, 4'b0111, 4'b0001, 0, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("hold_release", 3'b001, 4'b1110, 4'b0001, 0, 0);
  endtask

  task automatic test_leak();
    apply_reset();
    repeat (3) cycle(1, 4'b0100, 1, 0);
    repeat (4) cycle(1, 4'b0000, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    cycle(1, 4'b0100, 1, 0);
    expect_out("leak_first_err", 3'b000, 4'b0111, 4'b0000, 0, 0);
    cycle(1, 4'b0100, 1, 0);
    expect_out("leak_threshold", 3'b000, 4'b0111, 4'b0100, 0, 0);
  endtask

  task automatic test_double_fault();
    apply_reset();
    repeat (4) cycle(1, 4'b0101, 1, 0);
    expect_out("double_fault", 3'b000, 4'b0111, 4'b0101, 0, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("double_dmr", 3'b100, 4'b1010, 4'b0101, 1, 0);
  endtask

  task automatic test_mask_clear();
    apply_reset();
    repeat (5) cycle(1, 4'b1000, 1, 0);
    expect_out("mask_alu3", 3'b000, 4'b0111, 4'b0000, 0, 0);
    repeat (3) cycle(1, 4'b0001, 1, 0);
    cycle(1, 4'b0001, 1, 1);
    repeat (3) cycle(1, 4'b0001, 1, 0);
    expect_out("clear_wins", 3'b000, 4'b0111, 4'b0000, 0, 0);
    cycle(1, 4'b0001, 1, 0);
    expect_out("clear_then_fault", 3'b000, 4'b0111, 4'b0001, 0, 0);
  endtask

  task automatic test_full_degradation();
    apply_reset();
    repeat (4) cycle(1, 4'b0001, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("deg_spare", 3'b001, 4'b1110, 4'b0001, 0, 0);
    repeat (4) cycle(1, 4'b1000, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("deg_dmr", 3'b100, 4'b0110, 4'b1001, 1, 0);
    repeat (4) cycle(1, 4'b0010, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("deg_simplex", 3'b101, 4'b0100, 4'b1011, 1, 0);
    repeat (4) cycle(1, 4'b0100, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    expect_out("deg_failed", 3'b111, 4'b0000, 4'b1111, 0, 1);
    apply_reset();
    check_reset_vals("deg_reset_restore");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int i = 0; i < 150; i++)
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0000,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spare_swap();
    test_boundary_hold();
    test_leak();
    test_double_fault();
    test_mask_clear();
    test_full_degradation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
